// File: rtl/pattern_seq_ctrl.sv
// Triangle number-pattern sequencer: walks rows i=1..rows and columns j=1..i,
// streaming one value per beat with end-of-row and last-beat markers.
module pattern_seq_ctrl #(
  parameter int ROWS_W = 4,
  parameter int VAL_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ROWS_W-1:0] rows,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VAL_W-1:0]  out_data,
  output logic              out_eol,
  output logic              out_last,
  output logic              done,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ROWS_W-1:0] ROW_ONE = ROWS_W'(1);
  localparam logic [VAL_W-1:0]  VAL_ONE = VAL_W'(1);
  localparam logic              DIR_UP  = 1'b0;
  localparam logic              DIR_DN  = 1'b1;

  state_t            state;
  logic [1:0]        mode_q;
  logic [ROWS_W-1:0] rows_q;
  logic [ROWS_W-1:0] i;
  logic [ROWS_W-1:0] j;
  logic [ROWS_W-1:0] b;
  logic [VAL_W-1:0]  c;
  logic              dir;

  logic [ROWS_W-1:0] i_nxt;
  logic [ROWS_W-1:0] j_nxt;
  logic [ROWS_W-1:0] b_nxt;
  logic [VAL_W-1:0]  c_nxt;
  logic              dir_nxt;
  logic [VAL_W-1:0]  data_nxt;
  logic              eol_nxt;
  logic              last_nxt;
  logic              accept;

  // Zero-extend or truncate a row-domain value into the output value width.
  function automatic logic [VAL_W-1:0] to_val(input logic [ROWS_W-1:0] x);
    logic [ROWS_W+VAL_W-1:0] w;
    w = {{VAL_W{1'b0}}, x};
    return w[VAL_W-1:0];
  endfunction

  // Handshake: a beat transfers on any rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready is low, out_data/out_eol/out_last hold.
  assign accept    = out_valid && out_ready;
  assign fsm_state = state;

  // Counter values for the beat that follows the one currently presented.
  always_comb begin
    i_nxt   = i;
    j_nxt   = j;
    c_nxt   = c + VAL_ONE;
    b_nxt   = b;
    dir_nxt = dir;
    if (j < i) begin
      j_nxt = j + ROW_ONE;
    end else begin
      i_nxt = i + ROW_ONE;
      j_nxt = ROW_ONE;
    end
    if (rows_q == ROW_ONE) begin
      b_nxt   = ROW_ONE;
      dir_nxt = DIR_UP;
    end else if (dir == DIR_UP) begin
      b_nxt   = b + ROW_ONE;
      dir_nxt = (b_nxt == rows_q) ? DIR_DN : DIR_UP;
    end else begin
      b_nxt   = b - ROW_ONE;
      dir_nxt = (b_nxt == ROW_ONE) ? DIR_UP : DIR_DN;
    end
  end

  always_comb begin
    data_nxt = '0;
    case (mode_q)
      2'd0:    data_nxt = to_val(j_nxt);
      2'd1:    data_nxt = c_nxt;
      2'd2:    data_nxt = to_val(i_nxt - j_nxt + ROW_ONE);
      default: data_nxt = to_val(b_nxt);
    endcase
    eol_nxt  = (j_nxt == i_nxt);
    last_nxt = eol_nxt && (i_nxt == rows_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mode_q    <= '0;
      rows_q    <= '0;
      i         <= '0;
      j         <= '0;
      b         <= '0;
      c         <= '0;
      dir       <= DIR_UP;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (rows != '0) begin
              mode_q    <= mode;
              rows_q    <= rows;
              i         <= ROW_ONE;
              j         <= ROW_ONE;
              b         <= ROW_ONE;
              c         <= VAL_ONE;
              dir       <= DIR_UP;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              // Every mode starts its first beat at 1, and row 1 is one beat long.
              out_data  <= VAL_ONE;
              out_eol   <= 1'b1;
              out_last  <= (rows == ROW_ONE);
              state     <= RUN;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (out_last) begin
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_eol   <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              i        <= i_nxt;
              j        <= j_nxt;
              b        <= b_nxt;
              c        <= c_nxt;
              dir      <= dir_nxt;
              out_data <= data_nxt;
              out_eol  <= eol_nxt;
              out_last <= last_nxt;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Bench for pattern_seq_ctrl: a pattern model fills an expected-beat queue that a
// per-cycle compare process drains; directed sequences also pin literal results.
module tb_pattern_seq_ctrl;

  localparam int ROWS_W = 5;
  localparam int VAL_W  = 8;
  localparam int EW     = VAL_W + 2;

  logic              clk;
  logic              rst;
  logic              start;
  logic [1:0]        mode;
  logic [ROWS_W-1:0] rows;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [VAL_W-1:0]  out_data;
  logic              out_eol;
  logic              out_last;
  logic              done;
  logic [1:0]        fsm_state;

  pattern_seq_ctrl #(.ROWS_W(ROWS_W), .VAL_W(VAL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .rows      (rows),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_eol   (out_eol),
    .out_last  (out_last),
    .done      (done),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];   // {last, eol, data}
  logic [EW-1:0] cmp_e;
  int got_d[$];
  int got_e[$];
  int got_l[$];
  int lit_d[$];
  int lit_e[$];
  int lit_l[$];
  int checks     = 0;
  int failures   = 0;
  int beats_acc  = 0;
  int stall_beat = 0;
  int stall_left = 0;
  int busy_cnt   = 0;
  int done_at    = 0;
  bit done_pend  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Pattern model: rows enumerated as plain nested loops, bounce as a triangle wave.
  task automatic model_load(input int m, input int r);
    int k;
    int v;
    int p;
    logic [EW-1:0] e;
    k = 0;
    for (int ii = 1; ii <= r; ii++) begin
      for (int jj = 1; jj <= ii; jj++) begin
        case (m)
          0: v = jj;
          1: v = k + 1;
          2: v = ii - jj + 1;
          default: begin
            if (r == 1) v = 1;
            else begin
              p = k % (2 * (r - 1));
              v = (p < r - 1) ? p + 1 : 2 * r - 1 - p;
            end
          end
        endcase
        v = v % (1 << VAL_W);
        e[VAL_W-1:0] = v[VAL_W-1:0];
        e[VAL_W]     = (jj == ii);
        e[VAL_W+1]   = (ii == r) && (jj == ii);
        exp_q.push_back(e);
        k++;
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("done", done, done_pend);
    done_pend = 1'b0;
    if (exp_q.size() != 0) begin
      cmp_e = exp_q[0];
      chk("out_valid", out_valid, 1);
      chk("busy", busy, 1);
      chk("out_data", out_data, cmp_e[VAL_W-1:0]);
      chk("out_eol", out_eol, cmp_e[VAL_W]);
      chk("out_last", out_last, cmp_e[VAL_W+1]);
      if (out_valid && out_ready && rst) begin
        got_d.push_back(out_data);
        got_e.push_back(out_eol);
        got_l.push_back(out_last);
        void'(exp_q.pop_front());
        beats_acc++;
        if (cmp_e[VAL_W+1]) done_pend = 1'b1;
      end
    end else begin
      chk("idle_out_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
    end
  end

  // ---------------- ready driver ----------------
  always @(posedge clk) begin
    #1;
    if (stall_left > 0 && beats_acc + 1 == stall_beat) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_got();
    got_d.delete();
    got_e.delete();
    got_l.delete();
    beats_acc = 0;
  endtask

  task automatic issue_start(input int m, input int r);
    @(posedge clk);
    #1;
    start = 1'b1;
    mode  = 2'(m);
    rows  = ROWS_W'(r);
    @(posedge clk);
    #1;
    start = 1'b0;
    // Post-latch changes must not matter.
    mode  = 2'($urandom_range(0, 3));
    rows  = ROWS_W'($urandom_range(0, (1 << ROWS_W) - 1));
    model_load(m, r);
    if (r == 0) done_pend = 1'b1;
  endtask

  // sb/sl: stall out_ready for sl cycles when beat sb is presented.
  // ms: pulse start during RUN cycle ms (0 = never).
  task automatic run_seq(input string name, input int m, input int r,
                         input int sb, input int sl, input int ms);
    int cyc;
    bit got_done;
    @(negedge clk);
    clear_got();
    stall_beat = sb;
    stall_left = sl;
    busy_cnt   = 0;
    done_at    = 0;
    issue_start(m, r);
    cyc      = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (done) begin
        got_done = 1'b1;
        done_at  = cyc;
      end
      if (ms != 0 && cyc == ms) begin
        start = 1'b1;
        mode  = 2'($urandom_range(0, 3));
        rows  = ROWS_W'($urandom_range(1, (1 << ROWS_W) - 1));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({name, "_done_seen"}, got_done, 1);
    chk({name, "_busy_cycles"}, busy_cnt, r * (r + 1) / 2 + sl);
    chk({name, "_done_cycle"}, done_at, r * (r + 1) / 2 + sl + 1);
    repeat (2) @(negedge clk);
    chk({name, "_all_beats"}, exp_q.size(), 0);
  endtask

  task automatic check_lit(input string name);
    chk({name, "_len"}, got_d.size(), lit_d.size());
    if (got_d.size() == lit_d.size()) begin
      for (int k = 0; k < lit_d.size(); k++) begin
        chk($sformatf("%s_data[%0d]", name, k), got_d[k], lit_d[k]);
        if (lit_e.size() == lit_d.size())
          chk($sformatf("%s_eol[%0d]", name, k), got_e[k], lit_e[k]);
        if (lit_l.size() == lit_d.size())
          chk($sformatf("%s_last[%0d]", name, k), got_l[k], lit_l[k]);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    mode      = 2'd0;
    rows      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_eol", out_eol, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;

    run_seq("m0r4", 0, 4, 0, 0, 0);
    lit_d = '{1, 1, 2, 1, 2, 3, 1, 2, 3, 4};
    lit_e = '{1, 0, 1, 0, 0, 1, 0, 0, 0, 1};
    lit_l = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    check_lit("m0r4");

    run_seq("m1r4", 1, 4, 0, 0, 0);
    lit_d = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    check_lit("m1r4");

    run_seq("m2r3", 2, 3, 0, 0, 0);
    lit_d = '{1, 2, 1, 3, 2, 1};
    lit_e = '{1, 0, 1, 0, 0, 1};
    lit_l = '{0, 0, 0, 0, 0, 1};
    check_lit("m2r3");

    run_seq("m3r3", 3, 3, 0, 0, 0);
    lit_d = '{1, 2, 3, 2, 1, 2};
    check_lit("m3r3");

    run_seq("m3r1", 3, 1, 0, 0, 0);
    lit_d = '{1};
    lit_e = '{1};
    lit_l = '{1};
    check_lit("m3r1");

    run_seq("m0r3_stall", 0, 3, 2, 3, 0);
    lit_d = '{1, 1, 2, 1, 2, 3};
    lit_e = '{1, 0, 1, 0, 0, 1};
    lit_l = '{0, 0, 0, 0, 0, 1};
    check_lit("m0r3_stall");

    run_seq("rows0", 1, 0, 0, 0, 0);
    lit_d.delete();
    lit_e.delete();
    lit_l.delete();
    check_lit("rows0");

    run_seq("m0r4_midstart", 0, 4, 0, 0, 3);
    lit_d = '{1, 1, 2, 1, 2, 3, 1, 2, 3, 4};
    lit_e = '{1, 0, 1, 0, 0, 1, 0, 0, 0, 1};
    lit_l = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    check_lit("m0r4_midstart");

    // Abort with reset while beat 4 of mode 1 is presented.
    @(negedge clk);
    clear_got();
    issue_start(1, 4);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    done_pend = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_out_eol", out_eol, 0);
    chk("abort_out_last", out_last, 0);
    chk("abort_done", done, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    lit_d = '{1, 2, 3};
    lit_e.delete();
    lit_l.delete();
    check_lit("abort_prefix");

    run_seq("m1r4_restart", 1, 4, 0, 0, 0);
    lit_d = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    check_lit("m1r4_restart");

    // Larger shapes checked against the model only (count wraps past 255).
    run_seq("m3r2", 3, 2, 0, 0, 0);
    run_seq("m2r20", 2, 20, 5, 2, 0);
    run_seq("m1r31", 1, 31, 0, 0, 0);
    run_seq("m3r31", 3, 31, 100, 4, 0);
    run_seq("m0r31", 0, 31, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
